// File: rtl/ecc_secded_scrub_memory.sv
// SECDED (extended Hamming) protected single-port memory with an idle-time scrubber.
// User reads have two-cycle latency. A scrub step stalls the user port for 2 or 3 cycles.
module ecc_secded_scrub_memory #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 4,
    parameter int SCRUB_INTERVAL = 64,
    parameter int CNT_W          = 8,
    localparam int P    = (DATA_W <= 4)  ? 3 :
                          (DATA_W <= 11) ? 4 :
                          (DATA_W <= 26) ? 5 :
                          (DATA_W <= 57) ? 6 :
                          (DATA_W <= 120) ? 7 : 8,
    localparam int CW_W = DATA_W + P + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [CW_W-1:0]   inj_mask,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_sbe,
    output logic              rsp_dbe,
    input  logic              scrub_en,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  sbe_count,
    output logic [CNT_W-1:0]  dbe_count,
    output logic              dbe_seen,
    output logic [ADDR_W-1:0] dbe_addr,
    output logic [1:0]        scrub_state,
    output logic [ADDR_W-1:0] scrub_ptr
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int TMR_W = (SCRUB_INTERVAL > 2) ? $clog2(SCRUB_INTERVAL) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SCRUB_INTERVAL - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, S_READ = 2'd1, S_CHECK = 2'd2, S_WRITE = 2'd3} state_t;
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sbe;
        logic              dbe;
    } dec_t;

    function automatic logic [CW_W-1:0] encode(input logic [DATA_W-1:0] d);
        logic [CW_W-1:0] c;
        logic            b;
        int              k;
        c = '0;
        k = 0;
        for (int pos = 1; pos < CW_W; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos] = d[k];
                k++;
            end
        end
        // Parity positions are still zero here, so each parity bit only sums data bits.
        for (int i = 0; i < P; i++) begin
            b = 1'b0;
            for (int pos = 1; pos < CW_W; pos++)
                if (((pos >> i) & 1) != 0) b = b ^ c[pos];
            c[1 << i] = b;
        end
        c[0] = ^c[CW_W-1:1];
        return c;
    endfunction

    function automatic dec_t decode(input logic [CW_W-1:0] c);
        logic [P-1:0]    s;
        logic            q;
        logic [CW_W-1:0] fixed;
        dec_t            r;
        int              k;
        s = '0;
        for (int i = 0; i < P; i++)
            for (int pos = 1; pos < CW_W; pos++)
                if (((pos >> i) & 1) != 0) s[i] = s[i] ^ c[pos];
        q = ^c;
        fixed = c;
        if (q && (int'(s) < CW_W)) fixed[s] = ~fixed[s];
        r = '0;
        k = 0;
        for (int pos = 1; pos < CW_W; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                r.data[k] = fixed[pos];
                k++;
            end
        end
        r.sbe = q;
        r.dbe = !q && (s != '0);
        return r;
    endfunction

    state_t            state, state_next;
    logic [TMR_W-1:0]  timer;
    logic [CW_W-1:0]   mem [DEPTH];
    logic [CW_W-1:0]   rd_code, scrub_code;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_pend;
    logic              accept, go_scrub;
    logic              scrub_rd, scrub_chk, scrub_wr, step_done;
    logic              sbe_ev, dbe_ev;
    logic [ADDR_W-1:0] dbe_ev_addr;
    dec_t              rd_dec, scrub_dec;

    // Request handshake: a request transfers on a rising edge where req_valid && req_ready;
    // the requester holds req_valid and its fields stable until that edge.
    assign accept   = req_valid && req_ready;
    assign go_scrub = scrub_en && (timer == TMR_LAST) && !accept;
    assign rd_dec    = decode(rd_code);
    assign scrub_dec = decode(scrub_code);
    assign scrub_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (go_scrub) state_next = S_READ;
            S_READ:  state_next = S_CHECK;
            S_CHECK: state_next = scrub_dec.sbe ? S_WRITE : IDLE;
            S_WRITE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        scrub_rd  = (state == S_READ);
        scrub_chk = (state == S_CHECK);
        scrub_wr  = (state == S_WRITE);
        step_done = ((state == S_CHECK) && !scrub_dec.sbe) || (state == S_WRITE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (accept && req_we) begin
            mem[req_addr] <= encode(req_wdata) ^ inj_mask;
        end else if (scrub_wr) begin
            mem[scrub_ptr] <= encode(scrub_dec.data);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pend    <= 1'b0;
            rd_code    <= '0;
            rd_addr    <= '0;
            scrub_code <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_sbe    <= 1'b0;
            rsp_dbe    <= 1'b0;
        end else begin
            rd_pend <= accept && !req_we;
            if (accept && !req_we) begin
                rd_code <= mem[req_addr];
                rd_addr <= req_addr;
            end
            if (scrub_rd) scrub_code <= mem[scrub_ptr];
            rsp_valid <= rd_pend;
            rsp_sbe   <= rd_pend && rd_dec.sbe;
            rsp_dbe   <= rd_pend && rd_dec.dbe;
            if (rd_pend) rsp_rdata <= rd_dec.data;
        end
    end

    // A user decode and a scrub check never land on the same edge, so one event per edge suffices.
    assign sbe_ev      = (rd_pend && rd_dec.sbe) || (scrub_chk && scrub_dec.sbe);
    assign dbe_ev      = (rd_pend && rd_dec.dbe) || (scrub_chk && scrub_dec.dbe);
    assign dbe_ev_addr = rd_pend ? rd_addr : scrub_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sbe_count <= '0;
            dbe_count <= '0;
            dbe_seen  <= 1'b0;
            dbe_addr  <= '0;
        end else begin
            if (cnt_clr) begin
                sbe_count <= '0;
                dbe_count <= '0;
                dbe_seen  <= 1'b0;
            end else begin
                if (sbe_ev && (sbe_count != {CNT_W{1'b1}})) sbe_count <= sbe_count + 1'b1;
                if (dbe_ev && (dbe_count != {CNT_W{1'b1}})) dbe_count <= dbe_count + 1'b1;
                if (dbe_ev) dbe_seen <= 1'b1;
            end
            if (dbe_ev) dbe_addr <= dbe_ev_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer     <= '0;
            scrub_ptr <= '0;
        end else if (step_done) begin
            timer     <= '0;
            scrub_ptr <= scrub_ptr + 1'b1;
        end else if (state == IDLE) begin
            if (accept)                 timer <= '0;
            else if (timer != TMR_LAST) timer <= timer + 1'b1;
        end
    end
endmodule

// File: tb/tb_ecc_secded_scrub_memory.sv
// Directed bench for ecc_secded_scrub_memory: user path, ECC flags, counters, scrubber, reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_ecc_secded_scrub_memory;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int CW_W   = 13;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [CW_W-1:0]   inj_mask;
    logic              rsp_valid, rsp_sbe, rsp_dbe;
    logic [DATA_W-1:0] rsp_rdata;
    logic              scrub_en, cnt_clr;
    logic [CNT_W-1:0]  sbe_count, dbe_count;
    logic              dbe_seen;
    logic [ADDR_W-1:0] dbe_addr;
    logic [1:0]        scrub_state;
    logic [ADDR_W-1:0] scrub_ptr;

    int n_checks = 0;
    int n_pass   = 0;
    logic [DATA_W-1:0] exp_q[$];

    ecc_secded_scrub_memory #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SCRUB_INTERVAL(64), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .inj_mask(inj_mask),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_sbe(rsp_sbe), .rsp_dbe(rsp_dbe),
        .scrub_en(scrub_en), .cnt_clr(cnt_clr),
        .sbe_count(sbe_count), .dbe_count(dbe_count), .dbe_seen(dbe_seen), .dbe_addr(dbe_addr),
        .scrub_state(scrub_state), .scrub_ptr(scrub_ptr)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                              input logic [CW_W-1:0] m);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; inj_mask = m;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0; inj_mask = '0;
    endtask

    // Returns on the falling edge where rsp_valid was seen; lat = -1 if it never came.
    task automatic read_word(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d,
                             output logic sbe, output logic dbe, output int lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        @(negedge clk);
        req_valid = 1'b0;
        lat = -1; d = '0; sbe = 1'b0; dbe = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (rsp_valid === 1'b1) begin
                lat = i; d = rsp_rdata; sbe = rsp_sbe; dbe = rsp_dbe;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready); else n_pass++;
        n_checks++; if ({rsp_valid, rsp_sbe, rsp_dbe} !== 3'b000) $display("FAIL reset_rsp_flags: got %b want 000", {rsp_valid, rsp_sbe, rsp_dbe}); else n_pass++;
        n_checks++; if (rsp_rdata !== 8'h00) $display("FAIL reset_rdata: got %h want 00", rsp_rdata); else n_pass++;
        n_checks++; if ({sbe_count, dbe_count} !== 16'h0000) $display("FAIL reset_counts: got %h want 0000", {sbe_count, dbe_count}); else n_pass++;
        n_checks++; if ({dbe_seen, dbe_addr} !== 5'b0) $display("FAIL reset_dbe_info: got %b want 00000", {dbe_seen, dbe_addr}); else n_pass++;
        n_checks++; if ({scrub_state, scrub_ptr} !== 6'b0) $display("FAIL reset_fsm: got %b want 000000", {scrub_state, scrub_ptr}); else n_pass++;
        rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [DATA_W-1:0] d; logic s, b; int lat;
        write_word(4'd3, 8'hA5, '0);
        read_word(4'd3, d, s, b, lat);
        n_checks++; if (d !== 8'hA5) $display("FAIL basic_data: got %h want a5", d); else n_pass++;
        n_checks++; if ({s, b} !== 2'b00) $display("FAIL basic_flags: got %b want 00", {s, b}); else n_pass++;
        n_checks++; if (lat !== 2) $display("FAIL basic_latency: got %0d want 2", lat); else n_pass++;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL basic_pulse: got %b want 0", rsp_valid); else n_pass++;
    endtask

    task automatic test_sbe();
        logic [DATA_W-1:0] d; logic s, b; int lat;
        logic [CW_W-1:0] masks [3];
        masks[0] = 13'h0040; masks[1] = 13'h0001; masks[2] = 13'h1000;
        for (int i = 0; i < 3; i++) begin
            write_word(4'd5, 8'h3C, masks[i]);
            read_word(4'd5, d, s, b, lat);
            n_checks++; if (d !== 8'h3C) $display("FAIL sbe_data[%0d]: got %h want 3c", i, d); else n_pass++;
            n_checks++; if ({s, b} !== 2'b10) $display("FAIL sbe_flags[%0d]: got %b want 10", i, {s, b}); else n_pass++;
            n_checks++; if (sbe_count !== CNT_W'(i + 1)) $display("FAIL sbe_count[%0d]: got %0d want %0d", i, sbe_count, i + 1); else n_pass++;
        end
    endtask

    task automatic test_dbe();
        logic [DATA_W-1:0] d; logic s, b; int lat;
        write_word(4'd7, 8'h5A, 13'h0204);
        read_word(4'd7, d, s, b, lat);
        // Position 9 holds data bit 4, so the raw data differs from 0x5a in bit 4.
        n_checks++; if (d !== 8'h4A) $display("FAIL dbe_raw_data: got %h want 4a", d); else n_pass++;
        n_checks++; if ({s, b} !== 2'b01) $display("FAIL dbe_flags: got %b want 01", {s, b}); else n_pass++;
        n_checks++; if (dbe_count !== 8'd1) $display("FAIL dbe_count: got %0d want 1", dbe_count); else n_pass++;
        n_checks++; if ({dbe_seen, dbe_addr} !== 5'b1_0111) $display("FAIL dbe_seen_addr: got %b want 10111", {dbe_seen, dbe_addr}); else n_pass++;
        n_checks++; if (sbe_count !== 8'd3) $display("FAIL dbe_sbe_untouched: got %0d want 3", sbe_count); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] e;
        int got = 0;
        write_word(4'd9, 8'h77, '0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                got++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                n_checks++; if (rsp_rdata !== e) $display("FAIL b2b_data[%0d]: got %h want %h", got, rsp_rdata, e); else n_pass++;
            end
            case (c)
                0: begin req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd9; req_wdata = 8'hC3; end
                1: begin req_we = 1'b0; req_addr = 4'd9; exp_q.push_back(8'hC3); end
                2: begin req_addr = 4'd3; exp_q.push_back(8'hA5); end
                3: begin req_addr = 4'd9; exp_q.push_back(8'hC3); end
                default: req_valid = 1'b0;
            endcase
        end
        n_checks++; if (got !== 3) $display("FAIL b2b_count: got %0d want 3", got); else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_saturation();
        int resp = 0, bad = 0;
        logic [DATA_W-1:0] e;
        write_word(4'd2, 8'h96, 13'h0010);
        for (int c = 0; c < 305; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                resp++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                if (rsp_rdata !== e || rsp_sbe !== 1'b1) bad++;
            end
            if (c < 300) begin
                req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd2; exp_q.push_back(8'h96);
            end else begin
                req_valid = 1'b0;
            end
        end
        n_checks++; if (resp !== 300) $display("FAIL sat_responses: got %0d want 300", resp); else n_pass++;
        n_checks++; if (bad !== 0) $display("FAIL sat_bad_responses: got %0d want 0", bad); else n_pass++;
        n_checks++; if (sbe_count !== 8'd255) $display("FAIL sat_sbe_count: got %0d want 255", sbe_count); else n_pass++;
        n_checks++; if (dbe_count !== 8'd1) $display("FAIL sat_dbe_count: got %0d want 1", dbe_count); else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_cnt_clr();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd5;
        @(negedge clk);
        req_valid = 1'b0; cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        n_checks++; if ({rsp_valid, rsp_sbe} !== 2'b11) $display("FAIL clr_rsp: got %b want 11", {rsp_valid, rsp_sbe}); else n_pass++;
        n_checks++; if (sbe_count !== 8'd0) $display("FAIL clr_sbe_count: got %0d want 0", sbe_count); else n_pass++;
        n_checks++; if ({dbe_count, dbe_seen} !== 9'd0) $display("FAIL clr_dbe: got %h want 000", {dbe_count, dbe_seen}); else n_pass++;
    endtask

    task automatic test_scrub();
        logic [DATA_W-1:0] d; logic s, b; int lat;
        int low = 0;
        apply_reset();
        write_word(4'd0, 8'h81, 13'h0400);
        scrub_en = 1'b1;
        for (int c = 0; c < 74; c++) begin
            @(negedge clk);
            if (req_ready === 1'b0) low++;
        end
        scrub_en = 1'b0;
        n_checks++; if (low !== 3) $display("FAIL scrub_stall_cycles: got %0d want 3", low); else n_pass++;
        n_checks++; if (sbe_count !== 8'd1) $display("FAIL scrub_sbe_count: got %0d want 1", sbe_count); else n_pass++;
        n_checks++; if (scrub_ptr !== 4'd1) $display("FAIL scrub_ptr_step: got %0d want 1", scrub_ptr); else n_pass++;
        read_word(4'd0, d, s, b, lat);
        n_checks++; if ({d, s, b} !== {8'h81, 2'b00}) $display("FAIL scrub_fixed_read: got %h/%b%b want 81/00", d, s, b); else n_pass++;
    endtask

    task automatic test_sweep();
        int cyc = 0;
        bit saw_valid = 0;
        write_word(4'd4, 8'h00, 13'h0028);
        scrub_en = 1'b1;
        while (scrub_ptr !== 4'd0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid === 1'b1) saw_valid = 1;
        end
        n_checks++; if (scrub_ptr !== 4'd0) $display("FAIL sweep_wrap: got ptr %0d want 0 after %0d cycles", scrub_ptr, cyc); else n_pass++;
        n_checks++; if (saw_valid !== 1'b0) $display("FAIL sweep_rsp_valid: got %b want 0", saw_valid); else n_pass++;
        n_checks++; if ({dbe_count, dbe_seen, dbe_addr} !== {8'd1, 1'b1, 4'd4}) $display("FAIL sweep_dbe: got %0d/%b/%0d want 1/1/4", dbe_count, dbe_seen, dbe_addr); else n_pass++;
        n_checks++; if (sbe_count !== 8'd1) $display("FAIL sweep_sbe_count: got %0d want 1", sbe_count); else n_pass++;
    endtask

    task automatic test_wait_during_scrub();
        int cyc = 0, waits = 0;
        logic [DATA_W-1:0] e;
        while (req_ready !== 1'b0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++; if (req_ready !== 1'b0) $display("FAIL wait_scrub_start: got ready %b want 0", req_ready); else n_pass++;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd0; exp_q.push_back(8'h81);
        while (req_ready !== 1'b1 && waits < 10) begin
            @(negedge clk);
            waits++;
        end
        n_checks++; if (waits !== 2) $display("FAIL wait_stall: got %0d want 2", waits); else n_pass++;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        n_checks++; if ({rsp_valid, rsp_rdata} !== {1'b1, e}) $display("FAIL wait_response: got %b/%h want 1/%h", rsp_valid, rsp_rdata, e); else n_pass++;
    endtask

    task automatic test_scrub_disable();
        int cyc = 0, low = 0;
        while (req_ready !== 1'b0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        scrub_en = 1'b0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (req_ready === 1'b0) low++;
        end
        n_checks++; if (low !== 1) $display("FAIL disable_finish_step: got %0d want 1", low); else n_pass++;
        n_checks++; if ({scrub_state, scrub_ptr} !== {2'd0, 4'd2}) $display("FAIL disable_idle: got %0d/%0d want 0/2", scrub_state, scrub_ptr); else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        logic [DATA_W-1:0] d; logic s, b; int lat;
        int seen = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd0;
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 1) rst = 1'b1;
            if (rsp_valid !== 1'b0) seen++;
        end
        n_checks++; if (seen !== 0) $display("FAIL rstmid_no_valid: got %0d pulses want 0", seen); else n_pass++;
        n_checks++; if ({sbe_count, dbe_count, dbe_seen, dbe_addr} !== 21'd0) $display("FAIL rstmid_counters: got %h want 0", {sbe_count, dbe_count, dbe_seen, dbe_addr}); else n_pass++;
        n_checks++; if ({req_ready, scrub_state, scrub_ptr, rsp_rdata} !== {1'b1, 14'd0}) $display("FAIL rstmid_state: got %h want 4000", {req_ready, scrub_state, scrub_ptr, rsp_rdata}); else n_pass++;
        read_word(4'd0, d, s, b, lat);
        n_checks++; if ({d, s, b, lat} !== {8'h00, 2'b00, 32'd2}) $display("FAIL rstmid_mem_cleared: got %h/%b%b lat %0d want 00/00 lat 2", d, s, b, lat); else n_pass++;
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        inj_mask = '0; scrub_en = 1'b0; cnt_clr = 1'b0;
        test_reset();
        test_basic();
        test_sbe();
        test_dbe();
        test_back_to_back();
        test_saturation();
        test_cnt_clr();
        test_scrub();
        test_sweep();
        test_wait_during_scrub();
        test_scrub_disable();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ecc_secded_scrub_memory.md
# ecc_secded_scrub_memory

Parametrised SECDED-protected single-port memory with a background scrubber. Single-error correction, double-error detection, and error counting. Each user write is encoded into an extended Hamming codeword. Each user read is decoded and corrected, with single- and double-error flags. When the port is idle, a scrubber walks the array and writes corrected codewords back, so single-bit upsets cannot accumulate into uncorrectable errors.

## Interface
Parameters:
- DATA_W, 8, data word width (≥4)
- ADDR_W, 4, address width; DEPTH = 2^ADDR_W
- SCRUB_INTERVAL, 64, idle cycles before each scrub step (≥2)
- CNT_W, 8, width of error counters

Derived constants:
- P = smallest integer with 2^P ≥ DATA_W+P+1
- CW_W = DATA_W+P+1
- Defaults: P=4, CW_W=13

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  user request present
- req_ready  out  1  block accepts user request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- inj_mask  in  CW_W  XORed into the encoded codeword on user writes (fault injection; tie to 0 in mission mode)
- rsp_valid  out  1  one-cycle pulse, read data valid
- rsp_rdata  out  DATA_W  corrected read data
- rsp_sbe  out  1  single-bit error corrected on this read
- rsp_dbe  out  1  uncorrectable error on this read; rsp_rdata is raw data bits
- scrub_en  in  1  enable background scrubber
- cnt_clr  in  1  synchronous clear of counters and dbe_seen
- sbe_count  out  CNT_W  saturating count of corrected errors (user reads + scrub)
- dbe_count  out  CNT_W  saturating count of uncorrectable errors
- dbe_seen  out  1  sticky, set on any uncorrectable error
- dbe_addr  out  ADDR_W  address of most recent uncorrectable error

## Operation
Codeword layout:
- code[0] is overall parity: XOR of code[CW_W-1:1].
- code[1..CW_W-1] are Hamming positions 1..DATA_W+P.
- Parity bits sit at power-of-two positions; data bits fill the remaining positions in ascending order, LSB first.

Decode (all-zero codeword is valid):
- Syndrome s is P bits; overall parity check is q.
- s=0, q=0: clean.
- q=1: single error; flip position s, where s=0 means code[0]. Assert sbe.
- s≠0, q=0: double error; assert dbe, no correction.

Reset and storage:
- rst low clears every array word to all-zero, plus all counters, flags, FSM state and scrub pointer.

User access:
- Request is accepted when req_valid && req_ready.
- Write stores encode(req_wdata) ^ inj_mask.
- Read returns decoded data; the stored word is not modified by a user read.

Scrubber FSM:
- States: IDLE, S_READ, S_CHECK, S_WRITE.
- Idle timer increments each cycle with no accepted request; any accepted request resets it to 0.
- IDLE→S_READ when scrub_en=1 and timer = SCRUB_INTERVAL-1.
- S_READ: read array[scrub_ptr].
- S_CHECK: decode. On sbe, go to S_WRITE. On dbe, record dbe_addr and go to IDLE. On clean, go to IDLE.
- S_WRITE: write the re-encoded corrected data, then go to IDLE.
- On every exit to IDLE, scrub_ptr increments, wrapping DEPTH-1→0, and the timer clears.
- req_ready = 0 in S_READ, S_CHECK and S_WRITE; req_ready = 1 otherwise.
- scrub_en deasserted mid-step: the current step completes, then the FSM stays in IDLE.

Counters and flags:
- Counters increment by 1 per sbe/dbe event and saturate at 2^CNT_W-1.
- cnt_clr has priority over a same-cycle increment.
- dbe_seen is set on dbe and cleared only by cnt_clr or reset.

## Timing
- Reset values:
  - req_ready=1
  - rsp_valid=0, rsp_rdata=0, rsp_sbe=0, rsp_dbe=0
  - counters=0, dbe_seen=0, dbe_addr=0
  - FSM=IDLE, scrub_ptr=0, timer=0
- Write accepted at edge E0: the array is updated at E0.
- Read accepted at edge E0:
  - The codeword is registered at E0.
  - Decode is registered at E1.
  - rsp_valid and its data/flags are high in the cycle after E1 (latency 2), for exactly one cycle.
- Back-to-back reads return one response per cycle.
- Read-after-write to the same address in consecutive cycles returns the new data.
- The scrubber cannot start while a user read is in the pipeline; SCRUB_INTERVAL ≥ 2 guarantees this.
- The scrubber never asserts rsp_valid.
- Scrub step duration: 2 cycles clean or dbe, 3 cycles with writeback.
- Reset asserted mid-operation: any in-flight response and scrub step are dropped immediately.

## Test plan
- Write 0xA5 to addr 3, read addr 3 -> rsp_rdata=0xA5, sbe=0, dbe=0, 2-cycle latency.
- Write 0x3C to addr 5 with inj_mask bit 6 set, then read -> rsp_rdata=0x3C, rsp_sbe=1, sbe_count=1. Repeat with mask bit 0 -> same response, sbe_count=2.
- Write to addr 7 with inj_mask bits 2 and 9 set, then read -> rsp_dbe=1, dbe_count=1, dbe_seen=1, dbe_addr=7.
- Inject a single error at addr 0; scrub_en=1, idle 64 cycles -> req_ready low 3 cycles, sbe_count=1; a later user read of addr 0 gives sbe=0.
- Let the scrubber sweep all 16 addresses -> scrub_ptr wraps to 0.
- Raise req_valid during a scrub -> request waits until req_ready returns and is then accepted.
- Force 300 sbe events with CNT_W=8 -> sbe_count holds 255.
- Pulse cnt_clr together with an sbe event -> count=0.
- Assert rst during a read -> no rsp_valid, and all outputs read their reset values.
